// File: rtl/key_ctrl_pkg.sv
// rtl/key_ctrl_pkg.sv - shared types and constants for the key command arbiter
package key_ctrl_pkg;

  localparam int KEY_W_DEF = 5;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2 (
  input  logic Req0,
  input  logic Req1,
  input  logic LastGrant,
  output logic GrantValid,
  output logic GrantId
);

  always_comb begin
    GrantValid = Req0 | Req1;
    // On a tie the requester that did not win last time goes first.
    if (Req0 && Req1) begin
      GrantId = ~LastGrant;
    end else begin
      GrantId = Req1;
    end
  end

endmodule

// File: rtl/key_cmd_arbiter.sv
// rtl/key_cmd_arbiter.sv - arbitrates two key requesters onto one key command port
module key_cmd_arbiter
  import key_ctrl_pkg::*;
#(
  parameter int KEY_W       = KEY_W_DEF,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req0,
  input  logic [KEY_W-1:0] Key0,
  output logic             Ack0,
  input  logic             Req1,
  input  logic [KEY_W-1:0] Key1,
  output logic             Ack1,
  output logic [KEY_W-1:0] InputKey,
  output logic             ValidCmd,
  output logic             Busy,
  output logic             GrantId
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [KEY_W-1:0] cmd_key;
  logic             last_grant;
  logic             gnt_valid;
  logic             gnt_id;

  rr_arb2 u_rr_arb2 (
    .Req0       (Req0),
    .Req1       (Req1),
    .LastGrant  (last_grant),
    .GrantValid (gnt_valid),
    .GrantId    (gnt_id)
  );

  // The command register only reaches the port while the command is valid.
  assign InputKey = ValidCmd ? cmd_key : '0;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      cmd_key    <= '0;
      last_grant <= 1'b1;
      GrantId    <= 1'b0;
      ValidCmd   <= 1'b0;
      Busy       <= 1'b0;
      Ack0       <= 1'b0;
      Ack1       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          Ack0 <= 1'b0;
          Ack1 <= 1'b0;
          if (gnt_valid) begin
            cmd_key    <= gnt_id ? Key1 : Key0;
            GrantId    <= gnt_id;
            last_grant <= gnt_id;
            cnt        <= '0;
            ValidCmd   <= 1'b1;
            Busy       <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cnt == LAST_CNT) begin
            cnt      <= '0;
            ValidCmd <= 1'b0;
            Ack0     <= ~GrantId;
            Ack1     <= GrantId;
            state    <= ST_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GAP: begin
          Ack0  <= 1'b0;
          Ack1  <= 1'b0;
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          ValidCmd <= 1'b0;
          Busy     <= 1'b0;
          Ack0     <= 1'b0;
          Ack1     <= 1'b0;
          cnt      <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
